mem_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port synchronous memory (1-cycle read latency, byte write mask) between requester 0 (CPU) and requester 1 (DMA / debug loader).
- Uses the same strobe/mask memory protocol as the CPU core. An uncontended request passes through with zero added latency, so the existing CPU timing is unchanged.
- Contended requests are held in a per-requester slot and reported with busy flags.
- Round-robin fairness.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_req_slot.sv | 78 +++++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared ids and slot layout for the two-requester memory arbiter
package mem_arb_pkg;

  // Requester identities; also the encoding of last_grant and rd_tag.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Default slot field widths (addr / wdata / wmask / is_read).
  localparam int SLOT_ADDR_W  = 32;
  localparam int SLOT_DATA_W  = 32;
  localparam int SLOT_MASK_W  = SLOT_DATA_W / 8;
  localparam int SLOT_READ_W  = 1;

  // Byte-enable width for a given data width.
  function automatic int mask_width(input int data_w);
    return data_w / 8;
  endfunction

  // Total bits held by one request slot.
  function automatic int slot_bits(input int addr_w, input int data_w);
    return addr_w + data_w + mask_width(data_w) + SLOT_READ_W;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - per-requester hold slot, live/select mux and busy flags
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   addr/wdata/wmask    incoming request fields from the requester
//   rstrb               incoming read strobe
//   grant               this requester owns the memory this cycle
//   live                a request (held or new) is present this cycle
//   sel_addr/sel_wdata/sel_wmask/sel_read  request presented to the arbiter
//   rbusy, wbusy        held read / held write not yet issued
module mem_req_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [mask_width(DATA_W)-1:0] wmask,
  input  logic                          rstrb,
  input  logic                          grant,
  output logic                          live,
  output logic [ADDR_W-1:0]             sel_addr,
  output logic [DATA_W-1:0]             sel_wdata,
  output logic [mask_width(DATA_W)-1:0] sel_wmask,
  output logic                          sel_read,
  output logic                          rbusy,
  output logic                          wbusy
);

  localparam int MASK_W = mask_width(DATA_W);

  logic              pend;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  logic [MASK_W-1:0] slot_wmask;
  logic              slot_is_read;

  logic req_new;
  logic req_is_read;

  // Read and write strobes together count as a write.
  assign req_new     = rstrb | (|wmask);
  assign req_is_read = (wmask == '0);

  // A held slot always takes precedence; new strobes while held are dropped.
  assign live      = pend | req_new;
  assign sel_addr  = pend ? slot_addr    : addr;
  assign sel_wdata = pend ? slot_wdata   : wdata;
  assign sel_wmask = pend ? slot_wmask   : wmask;
  assign sel_read  = pend ? slot_is_read : req_is_read;

  assign rbusy = pend & slot_is_read;
  assign wbusy = pend & ~slot_is_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= 1'b0;
      slot_addr    <= '0;
      slot_wdata   <= '0;
      slot_wmask   <= '0;
      slot_is_read <= 1'b0;
    end else if (pend) begin
      if (grant) begin
        pend <= 1'b0;
      end
    end else if (req_new && !grant) begin
      pend         <= 1'b1;
      slot_addr    <= addr;
      slot_wdata   <= wdata;
      slot_wmask   <= wmask;
      slot_is_read <= req_is_read;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single-port synchronous memory
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mN_addr/mN_wdata/mN_wmask     requester N request fields (N = 0 CPU, 1 DMA)
//   mN_rstrb                      requester N read strobe
//   mN_rdata, mN_rvalid           requester N read return
//   mN_rbusy, mN_wbusy            requester N held read / held write
//   mem_addr/mem_wdata/mem_wmask/mem_rstrb  memory request
//   mem_rdata                     memory read data, one cycle after mem_rstrb
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             m0_addr,
  input  logic [DATA_W-1:0]             m0_wdata,
  input  logic [mask_width(DATA_W)-1:0] m0_wmask,
  input  logic                          m0_rstrb,
  output logic [DATA_W-1:0]             m0_rdata,
  output logic                          m0_rvalid,
  output logic                          m0_rbusy,
  output logic                          m0_wbusy,
  input  logic [ADDR_W-1:0]             m1_addr,
  input  logic [DATA_W-1:0]             m1_wdata,
  input  logic [mask_width(DATA_W)-1:0] m1_wmask,
  input  logic                          m1_rstrb,
  output logic [DATA_W-1:0]             m1_rdata,
  output logic                          m1_rvalid,
  output logic                          m1_rbusy,
  output logic                          m1_wbusy,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [mask_width(DATA_W)-1:0] mem_wmask,
  output logic                          mem_rstrb,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int MASK_W = mask_width(DATA_W);

  logic              live0, live1;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic [DATA_W-1:0] s0_wdata, s1_wdata;
  logic [MASK_W-1:0] s0_wmask, s1_wmask;
  logic              s0_read, s1_read;

  logic    gnt_valid;
  req_id_t gnt_id;
  req_id_t last_grant;
  req_id_t rd_tag;
  logic    rd_inflight;
  logic    gnt_read;

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .rst(rst),
    .addr(m0_addr), .wdata(m0_wdata), .wmask(m0_wmask), .rstrb(m0_rstrb),
    .grant(grant0), .live(live0),
    .sel_addr(s0_addr), .sel_wdata(s0_wdata), .sel_wmask(s0_wmask), .sel_read(s0_read),
    .rbusy(m0_rbusy), .wbusy(m0_wbusy)
  );

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .rst(rst),
    .addr(m1_addr), .wdata(m1_wdata), .wmask(m1_wmask), .rstrb(m1_rstrb),
    .grant(grant1), .live(live1),
    .sel_addr(s1_addr), .sel_wdata(s1_wdata), .sel_wmask(s1_wmask), .sel_read(s1_read),
    .rbusy(m1_rbusy), .wbusy(m1_wbusy)
  );

  // Tie break: fixed priority favours the CPU, otherwise whoever did not win last.
  always_comb begin
    gnt_valid = live0 | live1;
    gnt_id    = REQ_CPU;
    if (live0 && live1) begin
      if (FIXED_PRIO != 0) begin
        gnt_id = REQ_CPU;
      end else begin
        gnt_id = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
      end
    end else if (live1) begin
      gnt_id = REQ_DMA;
    end
  end

  assign grant0 = gnt_valid & (gnt_id == REQ_CPU);
  assign grant1 = gnt_valid & (gnt_id == REQ_DMA);

  // Memory-side mux; strobes are forced low while reset is held.
  always_comb begin
    mem_addr  = s0_addr;
    mem_wdata = s0_wdata;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
    gnt_read  = s0_read;
    if (gnt_id == REQ_DMA) begin
      mem_addr  = s1_addr;
      mem_wdata = s1_wdata;
      gnt_read  = s1_read;
    end
    if (gnt_valid && !rst) begin
      mem_rstrb = gnt_read;
      mem_wmask = gnt_read ? '0 : ((gnt_id == REQ_DMA) ? s1_wmask : s0_wmask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= REQ_DMA;
      rd_tag      <= REQ_CPU;
      rd_inflight <= 1'b0;
    end else begin
      if (gnt_valid) begin
        last_grant <= gnt_id;
      end
      rd_inflight <= gnt_valid & gnt_read;
      rd_tag      <= gnt_id;
    end
  end

  // Read data is a plain fan-out, qualified only by rvalid.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = rd_inflight & (rd_tag == REQ_CPU);
  assign m1_rvalid = rd_inflight & (rd_tag == REQ_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid, m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = '0;

  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_m0_rvalid, fp_m1_rvalid, fp_m0_rbusy, fp_m1_rbusy, fp_m0_wbusy, fp_m1_wbusy;
  logic [31:0] fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_wmask;
  logic        fp_mem_rstrb;
  logic [31:0] fp_mem_rdata = '0;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(fp_m0_rdata), .m0_rvalid(fp_m0_rvalid), .m0_rbusy(fp_m0_rbusy), .m0_wbusy(fp_m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(fp_m1_rdata), .m1_rvalid(fp_m1_rvalid), .m1_rbusy(fp_m1_rbusy), .m1_wbusy(fp_m1_wbusy),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
    .mem_rstrb(fp_mem_rstrb), .mem_rdata(fp_mem_rdata)
  );

  // Single-port synchronous memory with byte write enables, 1-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    m0_rstrb = 1'b0; m0_wmask = '0; m1_rstrb = 1'b0; m1_wmask = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(); idle(); rst = 1'b1;
    cyc(); rst = 1'b0;
  endtask

  logic [31:0] exp_a, prev_a;
  int          pc;

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 | (k * 4);
    mem[4] = 32'hDEAD_BEEF;
    mem[2] = 32'h5566_7788;

    // Reset state with requests present on the inputs.
    m0_rstrb = 1'b1; m1_wmask = 4'hF;
    @(negedge clk);
    chk("rst_rstrb", mem_rstrb, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_busy", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    cyc(); idle(); rst = 1'b0;

    // Uncontended read passes through with zero added latency.
    cyc(); m0_rstrb = 1'b1; m0_addr = 32'h10;
    @(negedge clk);
    chk("unc_rstrb", mem_rstrb, 1);
    chk("unc_addr", mem_addr, 32'h10);
    chk("unc_rbusy", m0_rbusy, 0);
    cyc(); idle();
    @(negedge clk);
    chk("unc_rvalid", m0_rvalid, 1);
    chk("unc_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("unc_rbusy2", m0_rbusy, 0);

    // Simultaneous reads right after reset: m0 first, m1 from its slot.
    do_reset();
    m0_rstrb = 1'b1; m0_addr = 32'h0; m1_rstrb = 1'b1; m1_addr = 32'h4;
    @(negedge clk);
    chk("sim_c0_addr", mem_addr, 32'h0);
    chk("sim_c0_rstrb", mem_rstrb, 1);
    cyc(); idle();
    @(negedge clk);
    chk("sim_c1_m1rbusy", m1_rbusy, 1);
    chk("sim_c1_addr", mem_addr, 32'h4);
    chk("sim_c1_rstrb", mem_rstrb, 1);
    chk("sim_c1_m0rvalid", m0_rvalid, 1);
    chk("sim_c1_m0rdata", m0_rdata, 32'h1000_0000);
    cyc();
    @(negedge clk);
    chk("sim_c2_m1rvalid", m1_rvalid, 1);
    chk("sim_c2_m1rdata", m1_rdata, 32'h1000_0004);
    chk("sim_c2_m1rbusy", m1_rbusy, 0);
    chk("sim_c2_m0rvalid", m0_rvalid, 0);

    // Saturation: grants alternate 0,1,0,1 and each return carries its own data.
    do_reset();
    prev_a = '0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      m0_rstrb = !m0_rbusy; m0_addr = 32'h20 + (c % 4) * 4;
      m1_rstrb = !m1_rbusy; m1_addr = 32'h40 + (c % 4) * 4;
      @(negedge clk);
      pc = (c == 0) ? 0 : c - 1;
      exp_a = (c % 2 == 0) ? 32'h20 + (pc % 4) * 4 : 32'h40 + (pc % 4) * 4;
      chk("rr_addr", mem_addr, exp_a);
      chk("rr_rstrb", mem_rstrb, 1);
      if (c > 0) begin
        if ((c - 1) % 2 == 0) begin
          chk("rr_m0rvalid", {m0_rvalid, m1_rvalid}, 32'h2);
          chk("rr_m0rdata", m0_rdata, 32'h1000_0000 | prev_a);
        end else begin
          chk("rr_m1rvalid", {m0_rvalid, m1_rvalid}, 32'h1);
          chk("rr_m1rdata", m1_rdata, 32'h1000_0000 | prev_a);
        end
      end
      prev_a = exp_a;
    end

    // Contended write held one cycle, then a read-back of the merged word.
    do_reset();
    m0_rstrb = 1'b1; m0_addr = 32'h0;
    m1_wmask = 4'b0011; m1_wdata = 32'h0000_ABCD; m1_addr = 32'h8;
    @(negedge clk);
    chk("wr_c0_addr", mem_addr, 32'h0);
    chk("wr_c0_wmask", mem_wmask, 0);
    cyc(); idle();
    @(negedge clk);
    chk("wr_c1_wbusy", m1_wbusy, 1);
    chk("wr_c1_rbusy", m1_rbusy, 0);
    chk("wr_c1_wmask", mem_wmask, 32'h3);
    chk("wr_c1_addr", mem_addr, 32'h8);
    chk("wr_c1_wdata", mem_wdata, 32'h0000_ABCD);
    chk("wr_c1_rstrb", mem_rstrb, 0);
    cyc(); m0_rstrb = 1'b1; m0_addr = 32'h8;
    @(negedge clk);
    chk("wr_c2_wbusy", m1_wbusy, 0);
    chk("wr_c2_rstrb", mem_rstrb, 1);
    cyc(); idle();
    @(negedge clk);
    chk("wr_c3_rvalid", m0_rvalid, 1);
    chk("wr_c3_rdata", m0_rdata, 32'h5566_ABCD);

    // Fixed priority: m0 always wins, m1 stays held.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      m0_rstrb = 1'b1; m0_addr = 32'h20; m1_rstrb = 1'b1; m1_addr = 32'h40;
      @(negedge clk);
      chk("fp_addr", fp_mem_addr, 32'h20);
      chk("fp_rstrb", fp_mem_rstrb, 1);
      if (c > 0) chk("fp_m1rbusy", fp_m1_rbusy, 1);
    end

    // Reset mid-operation drops the held slot and the in-flight read.
    do_reset();
    m0_rstrb = 1'b1; m0_addr = 32'h0; m1_rstrb = 1'b1; m1_addr = 32'h4;
    cyc(); idle(); rst = 1'b1;
    @(negedge clk);
    chk("mr_m1rbusy", m1_rbusy, 0);
    chk("mr_rstrb", mem_rstrb, 0);
    chk("mr_m0rvalid", m0_rvalid, 0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("mr_rel1_m1rvalid", m1_rvalid, 0);
    chk("mr_rel1_rstrb", mem_rstrb, 0);
    cyc();
    @(negedge clk);
    chk("mr_rel2_m1rvalid", m1_rvalid, 0);
    cyc(); m0_rstrb = 1'b1; m0_addr = 32'h10; m1_rstrb = 1'b1; m1_addr = 32'h4;
    @(negedge clk);
    chk("mr_tie_addr", mem_addr, 32'h10);
    cyc(); idle();
    @(negedge clk);
    chk("mr_tie_m0rvalid", m0_rvalid, 1);
    chk("mr_tie_m0rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("mr_tie_m1addr", mem_addr, 32'h4);
    cyc();
    @(negedge clk);
    chk("mr_tie_m1rdata", m1_rdata, 32'h1000_0004);
    chk("mr_tie_m1rvalid", m1_rvalid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
